sobel_frame_controller: RTL
===========================

SOBEL_FRAME_CONTROLLER -- requirements
Module: sobel_frame_controller

Interface
REQ-001 SHALL have parameter ROWS, default 242, frame height in pixels.
REQ-002 SHALL have parameter COLS, default 247, frame width in pixels.
REQ-003 SHALL have parameter MAG_W, default 11, width of the Sobel magnitude; 1443 max fits.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1  one-cycle frame-start request.
REQ-007 SHALL have port out_ready  input  1  downstream accepts the current window/normalize request.
REQ-008 SHALL have port mag_valid  input  1  Sobel core presents a magnitude result.
REQ-009 SHALL have port mag  input  MAG_W  magnitude result, unsigned.
REQ-010 SHALL have port pix_row  output  $clog2(ROWS)  current pixel row.
REQ-011 SHALL have port pix_col  output  $clog2(COLS)  current pixel column.
REQ-012 SHALL have port win_valid  output  1  pass-1 window request for (pix_row, pix_col).
REQ-013 SHALL have port border  output  1  current pixel lies on row 0, row ROWS-1, col 0 or col COLS-1.
REQ-014 SHALL have port norm_valid  output  1  pass-2 normalize request for (pix_row, pix_col).
REQ-015 SHALL have port max_mag  output  MAG_W  running/final maximum magnitude.
REQ-016 SHALL have port max_zero  output  1  pass 2 active with max_mag==0; downstream writes 0.
REQ-017 SHALL have port busy  output  1  high in any state except IDLE.
REQ-018 SHALL have port done  output  1  one-cycle frame-complete pulse.

Function
REQ-019 SHALL implement states IDLE, PASS1, DRAIN, PASS2, DONE.
REQ-020 SHALL leave IDLE for PASS1 on the edge where start=1; first win_valid the next cycle, row=col=0.
REQ-021 SHALL on entering PASS1 clear max_mag and the received-magnitude counter.
REQ-022 SHALL advance (row,col) only on a transfer (win_valid&out_ready or norm_valid&out_ready); hold all outputs stable otherwise.
REQ-023 SHALL scan raster order: col increments; at col==COLS-1 col wraps to 0 and row increments.
REQ-024 SHALL on the PASS1 transfer of (ROWS-1,COLS-1) go to DRAIN, deassert win_valid, reset row/col to 0.
REQ-025 SHALL in PASS1 and DRAIN count each mag_valid and set max_mag = max(max_mag, mag), strictly-greater update.
REQ-026 SHALL ignore mag_valid in IDLE, PASS2, DONE (no count, no max change).
REQ-027 SHALL leave DRAIN for PASS2 on the cycle the counter reaches ROWS*COLS, including a final mag_valid arriving in that same cycle.
REQ-028 SHALL accept mag_valid in PASS1 concurrently with window transfers (pipelined core, any latency).
REQ-029 SHALL in PASS2 assert norm_valid from row=col=0, freeze max_mag, drive max_zero=(max_mag==0).
REQ-030 SHALL on the PASS2 transfer of (ROWS-1,COLS-1) go to DONE; DONE asserts done for exactly one cycle then returns to IDLE.
REQ-031 SHALL ignore start whenever busy=1; start in the DONE cycle is also ignored.
REQ-032 SHALL drive border combinationally from pix_row/pix_col, valid whenever win_valid or norm_valid.
REQ-033 SHALL size the magnitude counter $clog2(ROWS*COLS+1) bits, never wrapping.

Reset
REQ-034 SHALL on rst=1 at any edge, including mid-frame, enter IDLE; win_valid, norm_valid, busy, done, max_zero, border-qualifying valids = 0; pix_row=pix_col=0; max_mag=0; counter=0.
REQ-035 SHALL give rst priority over start and all handshakes in the same cycle.

Verification
REQ-036 ROWS=3,COLS=4, out_ready=1, core latency 2, mags 0..11 -> 12 win_valid transfers, DRAIN, max_mag=11, 12 norm_valid, done pulse 1 cycle, busy low after.
REQ-037 Same, out_ready toggling 1/0 each cycle -> pix_row/pix_col held during stalls, still exactly 12 transfers per pass.
REQ-038 All mags=0 -> max_mag=0, max_zero=1 throughout PASS2, done asserted.
REQ-039 Last mag_valid 20 cycles after last window -> controller stays in DRAIN, busy=1, enters PASS2 the cycle count hits 12.
REQ-040 rst asserted during PASS2 at (1,2) -> next cycle IDLE, all outputs at reset values; new start runs full frame with fresh max.
REQ-041 start pulsed during PASS1 and in DONE cycle -> ignored, single frame only, one done pulse.

Source files
------------

// File: rtl/sobel_frame_controller.sv
// Two-pass frame sequencer for a Sobel pipeline: pass 1 streams window requests and
// tracks the peak magnitude, pass 2 streams normalize requests against that frozen peak.
module sobel_frame_controller #(
  parameter int ROWS  = 242,
  parameter int COLS  = 247,
  parameter int MAG_W = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     out_ready,
  input  logic                     mag_valid,
  input  logic [MAG_W-1:0]         mag,
  output logic [$clog2(ROWS)-1:0]  pix_row,
  output logic [$clog2(COLS)-1:0]  pix_col,
  output logic                     win_valid,
  output logic                     border,
  output logic                     norm_valid,
  output logic [MAG_W-1:0]         max_mag,
  output logic                     max_zero,
  output logic                     busy,
  output logic                     done
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam int TOTAL = ROWS * COLS;
  localparam int CNT_W = $clog2(TOTAL + 1);

  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS - 1);
  localparam logic [CNT_W-1:0] TOTAL_CNT = CNT_W'(TOTAL);

  typedef enum logic [2:0] {
    IDLE,
    PASS1,
    DRAIN,
    PASS2,
    DONE
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col;
  logic [MAG_W-1:0]   r_max;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cntNext;
  logic               w_lastPix;
  logic               w_xfer;
  logic               w_magAccept;

  assign w_lastPix   = (r_row == LAST_ROW) && (r_col == LAST_COL);
  assign w_xfer      = (win_valid || norm_valid) && out_ready;
  assign w_magAccept = mag_valid && ((r_state == PASS1) || (r_state == DRAIN));
  // Saturate so a stray extra result can never wrap the count back below the frame size
  assign w_cntNext   = (w_magAccept && (r_cnt != TOTAL_CNT)) ? r_cnt + 1'b1 : r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    win_valid   = 1'b0;
    norm_valid  = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_nextState = PASS1;
      end
      PASS1: begin
        win_valid = 1'b1;
        if (out_ready && w_lastPix) w_nextState = DRAIN;
      end
      DRAIN: begin
        if (w_cntNext == TOTAL_CNT) w_nextState = PASS2;
      end
      PASS2: begin
        norm_valid = 1'b1;
        if (out_ready && w_lastPix) w_nextState = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
    border = (win_valid || norm_valid) &&
             ((r_row == '0) || (r_row == LAST_ROW) || (r_col == '0) || (r_col == LAST_COL));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
      r_max <= '0;
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cntNext;
      if (w_magAccept && (mag > r_max)) r_max <= mag;
      // Raster wrap after the last pixel also leaves the scan at (0,0) for the next pass
      if (w_xfer) begin
        if (r_col == LAST_COL) begin
          r_col <= '0;
          r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if ((r_state == IDLE) && start) begin
        r_row <= '0;
        r_col <= '0;
        r_max <= '0;
        r_cnt <= '0;
      end
    end
  end

  assign pix_row  = r_row;
  assign pix_col  = r_col;
  assign max_mag  = r_max;
  assign max_zero = (r_state == PASS2) && (r_max == '0);

endmodule
